// File: rtl/training_set_loader_pkg.sv
// Shared types for the training set loader: the stored number format and the loader FSM states.
package training_set_loader_pkg;

  // Opaque number format; the loader only stores and forwards it.
  typedef logic [31:0] sfp;

  typedef enum logic [2:0] {
    LOAD,
    FULL,
    LAUNCH,
    WAIT,
    DONE
  } loader_state;

endpackage

// File: rtl/training_set_loader_sample_store.sv
// Dataset storage: one write port selected by slot index, whole array visible on the outputs.
module sample_store
  import training_set_loader_pkg::*;
#(
  parameter int size = 2,
  parameter int num = 4,
  localparam int IW = $clog2(num + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [IW-1:0]             wr_index,
  input  sfp   [size-1:0]           wr_features,
  input  sfp                        wr_expected,
  output sfp   [num-1:0][size-1:0]  features,
  output sfp   [num-1:0]            expected
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      features <= '0;
      expected <= '0;
    end else begin
      for (int i = 0; i < num; i++) begin
        if (wr_en && (wr_index == IW'(i))) begin
          features[i] <= wr_features;
          expected[i] <= wr_expected;
        end
      end
    end
  end

endmodule

// File: rtl/training_set_loader.sv
// Collects a full training dataset over a valid/ready stream and launches perceptron training runs on it.
module training_set_loader
  import training_set_loader_pkg::*;
#(
  parameter int size = 2,
  parameter int num = 4,
  localparam int CW = $clog2(num + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  sfp   [size-1:0]           in_features,
  input  sfp                        in_expected,
  input  logic                      clear,
  input  logic                      start,
  input  int                        cfg_epochs,
  input  sfp                        cfg_learning_rate,
  output sfp   [num-1:0][size-1:0]  train_values,
  output sfp   [num-1:0]            expected,
  output int                        epochs,
  output sfp                        learning_rate,
  output logic                      training,
  input  logic                      done_training,
  output logic [CW-1:0]             loaded_count,
  output logic                      busy,
  output logic                      run_done,
  output logic                      start_err
);

  loader_state state, next_state;
  logic        armed;
  logic        accept;
  logic        last_accept;
  logic        launch_req;

  // A clear arriving with a sample drops the sample, so the count restarts cleanly at zero.
  assign accept      = (state == LOAD) && in_valid && !clear;
  assign last_accept = accept && (loaded_count == CW'(num - 1));
  assign launch_req  = (state == FULL) && start && !clear;

  sample_store #(
    .size(size),
    .num (num)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (accept),
    .wr_index   (loaded_count),
    .wr_features(in_features),
    .wr_expected(in_expected),
    .features   (train_values),
    .expected   (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      loaded_count  <= '0;
      epochs        <= 0;
      learning_rate <= '0;
      armed         <= 1'b0;
      start_err     <= 1'b0;
    end else begin
      state     <= next_state;
      start_err <= (state == LOAD) && start;
      if (((state == LOAD) || (state == FULL)) && clear) begin
        loaded_count <= '0;
      end else if (accept) begin
        loaded_count <= loaded_count + CW'(1);
      end
      if (launch_req) begin
        epochs        <= (cfg_epochs < 1) ? 1 : cfg_epochs;
        learning_rate <= cfg_learning_rate;
      end
      // A done flag left high by the previous run must be seen low before it can end this one.
      if (state != WAIT) begin
        armed <= 1'b0;
      end else if (!done_training) begin
        armed <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    training   = 1'b0;
    busy       = 1'b0;
    run_done   = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (last_accept) next_state = FULL;
      end
      FULL: begin
        if (clear) next_state = LOAD;
        else if (start) next_state = LAUNCH;
      end
      LAUNCH: begin
        training   = 1'b1;
        busy       = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (armed && done_training) next_state = DONE;
      end
      DONE: begin
        run_done   = 1'b1;
        next_state = FULL;
      end
      default: next_state = LOAD;
    endcase
  end

endmodule

// File: tb/tb_training_set_loader.sv
// Randomised self-checking bench for training_set_loader against a dataset/run model kept in arrays.
module tb_training_set_loader;
  import training_set_loader_pkg::*;

  localparam int SIZE = 2;
  localparam int NUM = 4;
  localparam int CW = $clog2(NUM + 1);

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  sfp   [SIZE-1:0]           in_features;
  sfp                        in_expected;
  logic                      clear;
  logic                      start;
  int                        cfg_epochs;
  sfp                        cfg_learning_rate;
  sfp   [NUM-1:0][SIZE-1:0]  train_values;
  sfp   [NUM-1:0]            expected;
  int                        epochs;
  sfp                        learning_rate;
  logic                      training;
  logic                      done_training;
  logic [CW-1:0]             loaded_count;
  logic                      busy;
  logic                      run_done;
  logic                      start_err;

  int tests_run = 0;
  int tests_failed = 0;

  sfp model_feat [NUM][SIZE];
  sfp model_exp  [NUM];
  int model_count;

  training_set_loader #(.size(SIZE), .num(NUM)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_features      (in_features),
    .in_expected      (in_expected),
    .clear            (clear),
    .start            (start),
    .cfg_epochs       (cfg_epochs),
    .cfg_learning_rate(cfg_learning_rate),
    .train_values     (train_values),
    .expected         (expected),
    .epochs           (epochs),
    .learning_rate    (learning_rate),
    .training         (training),
    .done_training    (done_training),
    .loaded_count     (loaded_count),
    .busy             (busy),
    .run_done         (run_done),
    .start_err        (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; start = 1'b0; done_training = 1'b0;
    cfg_epochs = 0; cfg_learning_rate = '0; in_features = '0; in_expected = '0;
    step; step;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (loaded_count !== '0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", loaded_count); end
    tests_run++; if ({training, busy, run_done, start_err} !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 0000", {training, busy, run_done, start_err}); end
    tests_run++; if ((epochs !== 0) || (learning_rate !== '0)) begin tests_failed++; $display("[TB] FAIL reset_latches: got %0d/%0h expected 0/0", epochs, learning_rate); end
    bad = 0;
    for (int i = 0; i < NUM; i++) begin
      if (expected[i] !== '0) bad++;
      for (int j = 0; j < SIZE; j++) if (train_values[i][j] !== '0) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL reset_storage: got %0d nonzero words expected 0", bad); end
    rst_n = 1'b1;
    step;
    model_count = 0;
    for (int i = 0; i < NUM; i++) begin
      model_exp[i] = '0;
      for (int j = 0; j < SIZE; j++) model_feat[i][j] = '0;
    end
  endtask

  task automatic test_load(input bit full_rate, input int max_samples);
    int cycles;
    int bad;
    bit acc;
    cycles = 0;
    while ((model_count < max_samples) && (cycles < 200)) begin
      in_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
      for (int j = 0; j < SIZE; j++) in_features[j] = $urandom;
      in_expected = $urandom;
      acc = in_valid;
      step;
      cycles++;
      if (acc) begin
        for (int j = 0; j < SIZE; j++) model_feat[model_count][j] = in_features[j];
        model_exp[model_count] = in_expected;
        model_count++;
      end
      tests_run++; if (loaded_count !== CW'(model_count)) begin tests_failed++; $display("[TB] FAIL load_count: got %0d expected %0d", loaded_count, model_count); end
      tests_run++; if (in_ready !== (model_count < NUM)) begin tests_failed++; $display("[TB] FAIL load_in_ready: got %b expected %b", in_ready, (model_count < NUM)); end
    end
    in_valid = 1'b0;
    tests_run++; if (model_count < max_samples) begin tests_failed++; $display("[TB] FAIL load_timeout: got %0d samples expected %0d", model_count, max_samples); end
    bad = 0;
    for (int i = 0; i < NUM; i++) begin
      if (expected[i] !== model_exp[i]) bad++;
      for (int j = 0; j < SIZE; j++) if (train_values[i][j] !== model_feat[i][j]) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL load_arrays: got %0d wrong words expected 0", bad); end
    if (model_count == NUM) begin
      in_valid = 1'b1;
      for (int j = 0; j < SIZE; j++) in_features[j] = $urandom;
      in_expected = $urandom;
      step;
      in_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < NUM; i++) begin
        if (expected[i] !== model_exp[i]) bad++;
        for (int j = 0; j < SIZE; j++) if (train_values[i][j] !== model_feat[i][j]) bad++;
      end
      tests_run++; if ((bad != 0) || (loaded_count !== CW'(NUM))) begin tests_failed++; $display("[TB] FAIL full_ignores_valid: got %0d wrong words count %0d expected 0 and %0d", bad, loaded_count, NUM); end
    end
  endtask

  task automatic test_start_err;
    int bad;
    test_load(1'b1, 2);
    start = 1'b1;
    step;
    start = 1'b0;
    tests_run++; if ((start_err !== 1'b1) || (training !== 1'b0)) begin tests_failed++; $display("[TB] FAIL start_err_pulse: got err=%b training=%b expected 1/0", start_err, training); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_err_stay_load: got in_ready %b expected 1", in_ready); end
    step;
    tests_run++; if ({start_err, training, busy} !== 3'b000 || loaded_count !== CW'(2)) begin tests_failed++; $display("[TB] FAIL start_err_one_cycle: got flags %b count %0d expected 000 and 2", {start_err, training, busy}, loaded_count); end
    clear = 1'b1;
    step;
    clear = 1'b0;
    model_count = 0;
    bad = 0;
    for (int i = 0; i < NUM; i++) begin
      if (expected[i] !== model_exp[i]) bad++;
      for (int j = 0; j < SIZE; j++) if (train_values[i][j] !== model_feat[i][j]) bad++;
    end
    tests_run++; if ((loaded_count !== '0) || (in_ready !== 1'b1) || (bad != 0)) begin tests_failed++; $display("[TB] FAIL clear_in_load: got count %0d ready %b wrong words %0d expected 0/1/0", loaded_count, in_ready, bad); end
  endtask

  task automatic test_run;
    int spurious;
    sfp lr;
    lr = 32'h3DCCCCCD;
    cfg_epochs = 10;
    cfg_learning_rate = lr;
    start = 1'b1;
    step;
    start = 1'b0;
    cfg_epochs = 77;
    cfg_learning_rate = $urandom;
    tests_run++; if ((training !== 1'b1) || (busy !== 1'b1)) begin tests_failed++; $display("[TB] FAIL run_launch: got training=%b busy=%b expected 1/1", training, busy); end
    tests_run++; if ((epochs !== 10) || (learning_rate !== lr)) begin tests_failed++; $display("[TB] FAIL run_latch: got %0d/%0h expected 10/%0h", epochs, learning_rate, lr); end
    spurious = 0;
    for (int c = 0; c < 50; c++) begin
      step;
      if ((training !== 1'b0) || (run_done !== 1'b0) || (busy !== 1'b1) || (epochs !== 10) || (learning_rate !== lr)) spurious++;
    end
    tests_run++; if (spurious != 0) begin tests_failed++; $display("[TB] FAIL run_wait: got %0d bad cycles expected 0", spurious); end
    done_training = 1'b1;
    step;
    tests_run++; if ((run_done !== 1'b1) || (busy !== 1'b0)) begin tests_failed++; $display("[TB] FAIL run_done_pulse: got done=%b busy=%b expected 1/0", run_done, busy); end
    step;
    tests_run++; if ((run_done !== 1'b0) || (in_ready !== 1'b0) || (loaded_count !== CW'(NUM))) begin tests_failed++; $display("[TB] FAIL run_back_full: got done=%b ready=%b count=%0d expected 0/0/%0d", run_done, in_ready, loaded_count, NUM); end
  endtask

  task automatic test_stale_done_back_to_back;
    int spurious;
    int ep;
    sfp lr;
    ep = int'($urandom_range(1, 1000));
    lr = $urandom;
    cfg_epochs = ep;
    cfg_learning_rate = lr;
    start = 1'b1;
    step;
    start = 1'b0;
    tests_run++; if ((training !== 1'b1) || (epochs !== ep) || (learning_rate !== lr)) begin tests_failed++; $display("[TB] FAIL stale_launch: got training=%b epochs=%0d lr=%0h expected 1/%0d/%0h", training, epochs, learning_rate, ep, lr); end
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      step;
      if ((run_done !== 1'b0) || (busy !== 1'b1)) spurious++;
    end
    tests_run++; if (spurious != 0) begin tests_failed++; $display("[TB] FAIL stale_done_ignored: got %0d bad cycles expected 0", spurious); end
    done_training = 1'b0;
    step;
    done_training = 1'b1;
    step;
    tests_run++; if (run_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL stale_rearm_done: got %b expected 1", run_done); end
    done_training = 1'b0;
    step;
    tests_run++; if ({run_done, busy, in_ready} !== 3'b000) begin tests_failed++; $display("[TB] FAIL b2b_full: got %b expected 000", {run_done, busy, in_ready}); end
    lr = $urandom;
    cfg_epochs = 0;
    cfg_learning_rate = lr;
    start = 1'b1;
    step;
    start = 1'b0;
    tests_run++; if ((training !== 1'b1) || (epochs !== 1) || (learning_rate !== lr)) begin tests_failed++; $display("[TB] FAIL b2b_epochs_zero: got training=%b epochs=%0d lr=%0h expected 1/1/%0h", training, epochs, learning_rate, lr); end
    step;
    step;
    done_training = 1'b1;
    step;
    tests_run++; if (run_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_done: got %b expected 1", run_done); end
    done_training = 1'b0;
    step;
  endtask

  task automatic test_clear_start;
    clear = 1'b1;
    start = 1'b1;
    step;
    clear = 1'b0;
    start = 1'b0;
    tests_run++; if ((in_ready !== 1'b1) || (loaded_count !== '0) || (training !== 1'b0) || (busy !== 1'b0)) begin tests_failed++; $display("[TB] FAIL clear_wins: got ready=%b count=%0d training=%b busy=%b expected 1/0/0/0", in_ready, loaded_count, training, busy); end
    step;
    tests_run++; if ((training !== 1'b0) || (start_err !== 1'b0)) begin tests_failed++; $display("[TB] FAIL clear_no_launch: got training=%b err=%b expected 0/0", training, start_err); end
    model_count = 0;
  endtask

  task automatic test_reset_mid_wait;
    cfg_epochs = 5;
    cfg_learning_rate = $urandom;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    tests_run++; if ((busy !== 1'b1) || (training !== 1'b0)) begin tests_failed++; $display("[TB] FAIL rst_pre_wait: got busy=%b training=%b expected 1/0", busy, training); end
    rst_n = 1'b0;
    #1;
    tests_run++; if ((in_ready !== 1'b1) || (busy !== 1'b0) || (loaded_count !== '0) || (epochs !== 0) || (learning_rate !== '0) || (train_values !== '0) || (expected !== '0)) begin tests_failed++; $display("[TB] FAIL rst_async: got ready=%b busy=%b count=%0d epochs=%0d expected 1/0/0/0", in_ready, busy, loaded_count, epochs); end
    step;
    rst_n = 1'b1;
    step;
    tests_run++; if ((in_ready !== 1'b1) || (busy !== 1'b0) || (loaded_count !== '0) || (run_done !== 1'b0)) begin tests_failed++; $display("[TB] FAIL rst_release_load: got ready=%b busy=%b count=%0d done=%b expected 1/0/0/0", in_ready, busy, loaded_count, run_done); end
  endtask

  initial begin
    test_reset;
    test_start_err;
    test_load(1'b1, NUM);
    test_run;
    test_stale_done_back_to_back;
    test_clear_start;
    test_load(1'b0, NUM);
    test_reset_mid_wait;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
